multi_seq: RTL and testbench
============================

# multi_seq

Sequential 32×32 signed two's-complement multiplier producing a 64-bit product, with a start/valid handshake. Sits as an arithmetic co-processor block; the operation starts on a rising edge of `start` and `valid` pulses once when `prodt` holds the result. Two variants are selected by parameter. The fixed-latency variant (`multi`) always takes 33 cycles. The variable-latency variant (`multi_vl`) terminates early based on the multiplier magnitude.

## Interface
- `VAR_LATENCY`, default 0 — 0: fixed latency (`multi`); 1: early-terminating (`multi_vl`).
- `WIDTH`, default 32 — operand width. Product width is 2·`WIDTH`.
- `clock`  in  1 — rising-edge clock.
- `reset`  in  1 — asynchronous, active-high reset.
- `mlier`  in  32 — multiplier, signed. Sampled only at the start edge.
- `mcand`  in  32 — multiplicand, signed. Sampled only at the start edge.
- `prodt`  out 64 — signed product, registered.
- `start`  in  1 — level input. An operation begins on its 0→1 transition.
- `valid`  out 1 — one-cycle pulse; `prodt` is correct while it is high.

## Operation
- **Reset:**
  - `reset` = 1 → `prodt` = 0, `valid` = 0, state IDLE, internal `start_q` = 0.
  - Mid-operation reset aborts the operation with no `valid`.
- **Start detect:** `start & ~start_q`, where `start_q` is `start` registered.
  - Holding `start` high after the edge never retriggers.
  - A start edge while BUSY is ignored.
- **Edge cycle (E0):**
  - Capture `sign = mlier[31] ^ mcand[31]`.
  - Capture `|mlier|` and `|mcand|` as 32-bit unsigned. `|0x80000000|` = 2^31, with no overflow.
  - Clear the 64-bit accumulator; go to BUSY.
- **Iteration (one per cycle):**
  - If the multiplier LSB is 1, add the shifted `|mcand|` into the accumulator.
  - Shift the multiplier right by 1.
- **Completion:**
  - `prodt <= sign ? -acc : acc`, computed in 64 bits. Zero stays zero; no negative zero.
  - `valid <= 1` for exactly one cycle; return to IDLE.
  - `prodt` holds its value until the next completion or reset.
- **FSM:** IDLE → (start edge) → BUSY → (last iteration) → DONE (`valid`) → IDLE.
- **Result:** `prodt` equals the exact signed 64-bit product of all 2^64 operand pairs. No truncation or saturation.
- **Variable latency (`VAR_LATENCY` = 1):**
  - BUSY ends once the remaining multiplier bits are all zero.
  - If either operand is 0 at E0, exactly one BUSY cycle runs.

## Timing
- n is the count of rising edges after E0 at which `valid` is first sampled high.
- Fixed variant: n = 33 for every operand pair.
  - 32 iterations at E1..E32; `valid`/`prodt` registered at E32.
- Variable variant: n = max(L, 1) + 1, where L = bit length of `|mlier|` (0..32).
  - Zero operand → n = 2; `mlier` = 1 → n = 2; `mlier` = 0x80000000 → n = 33.
- Hard bound for both variants: n ≤ 33.
- Back-to-back use: a new start edge is accepted the cycle after DONE.
- `mlier`/`mcand` may change freely after E0.

## Structure
- **Shared package `multi_pkg`:**
  - `WIDTH` = 32 and `PWIDTH` = 64.
  - `FIX_LAT` = 33.
  - FSM state enum {IDLE, BUSY, DONE}.
- **Wrappers:** `multi` and `multi_vl` are thin wrappers setting `VAR_LATENCY` = 0 / 1.
- **Sub-module `multi_core`:** shift-add datapath (magnitude conversion, accumulator, final conditional negate). One instance, controlled by the FSM in the top.

## Test plan
Each case: hold `start` for 33 cycles, drop it for 5 cycles, then issue the next case.
- 0x00000001 × 0x7FFFFFFF → 0x000000007FFFFFFF; fixed n = 33, VL n = 2.
- 0x7FFFFFFF × 0x7FFFFFFF → 0x3FFFFFFF00000001.
- 0x7FFFFFFF × 0x80000000 → 0xC000000080000000.
- 0x80000000 × 0x80000000 → 0x4000000000000000; VL n = 33.
- 0xFFFFFFFF × 0xFFFFFFFF → 0x0000000000000001.
- 0x80000000 × 0xFFFFFFFF → 0x0000000080000000.
- 0x00000000 × 0x80000000 → 0x0000000000000000; exactly one `valid` pulse; VL n = 2.
- Reset asserted mid-operation → `valid` stays 0 and `prodt` = 0; the next start edge yields the correct product.
- Every case must also check:
  - exactly one `valid` pulse per start edge;
  - no `valid` while `start` is held;
  - n ≤ 33.

Source files
------------

// File: rtl/multi_pkg.sv
// Shared constants and FSM state type for the sequential signed multiplier.
package multi_pkg;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned PWIDTH  = 2 * WIDTH;
  localparam int unsigned FIX_LAT = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/multi_core.sv
// Shift-add datapath: operand magnitudes, 2W-bit accumulator and final sign fix-up.
module multi_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mlier,
  input  logic [WIDTH-1:0]     mcand,
  output logic                 last_vl,
  output logic [2*WIDTH-1:0]   result
);
  localparam int unsigned PW = 2 * WIDTH;

  // The most negative operand maps to 2^(W-1), which still fits unsigned W bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  logic              sign_q,  sign_d;
  logic [WIDTH-1:0]  mlier_q, mlier_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     acc_q,   acc_d;
  logic [PW-1:0]     acc_nxt;
  logic [WIDTH-1:0]  mlier_mag, mcand_mag;

  assign mlier_mag = mag(mlier);
  assign mcand_mag = mag(mcand);
  assign acc_nxt   = acc_q + (mlier_q[0] ? mcand_q : '0);
  assign result    = sign_q ? -acc_nxt : acc_nxt;
  assign last_vl   = ~|mlier_q[WIDTH-1:1];

  always_comb begin
    sign_d  = sign_q;
    mlier_d = mlier_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (load) begin
      sign_d  = mlier[WIDTH-1] ^ mcand[WIDTH-1];
      // A zero multiplicand clears the multiplier so early termination fires at once.
      mlier_d = (mcand_mag == '0) ? '0 : mlier_mag;
      mcand_d = PW'(mcand_mag);
      acc_d   = '0;
    end else if (step) begin
      acc_d   = acc_nxt;
      mlier_d = mlier_q >> 1;
      mcand_d = mcand_q << 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_q  <= 1'b0;
      mlier_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      sign_q  <= sign_d;
      mlier_q <= mlier_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: rtl/multi_wrappers.sv
// Thin fixed-latency (multi) and early-terminating (multi_vl) variants of multi_seq.
module multi (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  mlier,
  input  logic [31:0]  mcand,
  output logic [63:0]  prodt,
  input  logic         start,
  output logic         valid
);
  multi_seq #(.VAR_LATENCY(0), .WIDTH(32)) u_seq (
    .clock (clock),
    .reset (reset),
    .mlier (mlier),
    .mcand (mcand),
    .prodt (prodt),
    .start (start),
    .valid (valid)
  );
endmodule

module multi_vl (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  mlier,
  input  logic [31:0]  mcand,
  output logic [63:0]  prodt,
  input  logic         start,
  output logic         valid
);
  multi_seq #(.VAR_LATENCY(1), .WIDTH(32)) u_seq (
    .clock (clock),
    .reset (reset),
    .mlier (mlier),
    .mcand (mcand),
    .prodt (prodt),
    .start (start),
    .valid (valid)
  );
endmodule

// File: rtl/multi_seq.sv
// Sequential signed multiplier with start-edge / valid-pulse handshake; fixed or early-terminating.
module multi_seq #(
  parameter int unsigned VAR_LATENCY = 0,
  parameter int unsigned WIDTH       = multi_pkg::WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mlier,
  input  logic [WIDTH-1:0]     mcand,
  output logic [2*WIDTH-1:0]   prodt,
  input  logic                 start,
  output logic                 valid
);
  import multi_pkg::*;

  localparam int unsigned CW = $clog2(WIDTH);

  state_t               state_q, state_d;
  logic                 start_q, start_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic                 valid_q, valid_d;
  logic [2*WIDTH-1:0]   prodt_q, prodt_d;
  logic                 load, step, last, last_vl, start_edge;
  logic [2*WIDTH-1:0]   result;

  assign start_d    = start;
  assign start_edge = start & ~start_q;
  assign last       = (VAR_LATENCY != 0) ? last_vl : (cnt_q == CW'(WIDTH - 1));
  assign prodt      = prodt_q;
  assign valid      = valid_q;

  multi_core #(.WIDTH(WIDTH)) u_core (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .mlier   (mlier),
    .mcand   (mcand),
    .last_vl (last_vl),
    .result  (result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    prodt_d = prodt_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Final iteration and sign fix-up land in the same edge.
        if (last) begin
          prodt_d = result;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      prodt_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      prodt_q <= prodt_d;
    end
  end
endmodule

// File: tb/tb_multi_seq.sv
// Directed bench: fixed multi_seq, multi wrapper and multi_vl driven in parallel from one stimulus.
module tb_multi_seq;
  import multi_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   mlier = '0;
  logic [WIDTH-1:0]   mcand = '0;
  logic [PWIDTH-1:0]  prodt_f, prodt_w, prodt_v;
  logic               valid_f, valid_w, valid_v;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  multi_seq #(.VAR_LATENCY(0), .WIDTH(32)) u_fix (
    .clock (clock), .reset (reset), .mlier (mlier), .mcand (mcand),
    .prodt (prodt_f), .start (start), .valid (valid_f)
  );

  multi u_wrap (
    .clock (clock), .reset (reset), .mlier (mlier), .mcand (mcand),
    .prodt (prodt_w), .start (start), .valid (valid_w)
  );

  multi_vl u_vl (
    .clock (clock), .reset (reset), .mlier (mlier), .mcand (mcand),
    .prodt (prodt_v), .start (start), .valid (valid_v)
  );

  function automatic logic get_valid(input int i);
    case (i)
      0:       return valid_f;
      1:       return valid_w;
      default: return valid_v;
    endcase
  endfunction

  function automatic logic [PWIDTH-1:0] get_prodt(input int i);
    case (i)
      0:       return prodt_f;
      1:       return prodt_w;
      default: return prodt_v;
    endcase
  endfunction

  // Entered and left on a falling edge. Start is seen high at E0..E32, then low for gap edges.
  task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int n_vl, input int gap);
    int          n[3];
    int          pulses[3];
    logic [63:0] got[3];
    int          exp_n;
    for (int i = 0; i < 3; i++) begin
      n[i] = -1; pulses[i] = 0; got[i] = '0;
    end
    mlier = a;
    mcand = b;
    start = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 32 + gap; k++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (get_valid(i) === 1'b1) begin
          pulses[i]++;
          if (n[i] < 0) begin
            n[i]   = k + 1;
            got[i] = get_prodt(i);
          end
        end
      end
      @(negedge clock);
      if (k == 1) begin
        mlier = ~a ^ 32'h5A5A_0F0F;
        mcand = b + 32'h0000_1357;
      end
      if (k == 32) start = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      exp_n = (i == 2) ? n_vl : FIX_LAT;
      tests_run++;
      if (pulses[i] !== 1) begin
        tests_failed++;
        $display("FAIL %s[%0d] valid pulses: got %0d want 1", name, i, pulses[i]);
      end
      tests_run++;
      if (n[i] !== exp_n) begin
        tests_failed++;
        $display("FAIL %s[%0d] latency n: got %0d want %0d", name, i, n[i], exp_n);
      end
      tests_run++;
      if (got[i] !== exp) begin
        tests_failed++;
        $display("FAIL %s[%0d] prodt at valid: got %h want %h", name, i, got[i], exp);
      end
      tests_run++;
      if (get_prodt(i) !== exp) begin
        tests_failed++;
        $display("FAIL %s[%0d] prodt hold: got %h want %h", name, i, get_prodt(i), exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (get_valid(i) !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset[%0d] valid: got %b want 0", i, get_valid(i));
      end
      tests_run++;
      if (get_prodt(i) !== 64'h0) begin
        tests_failed++;
        $display("FAIL reset[%0d] prodt: got %h want 0", i, get_prodt(i));
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_products();
    run_case("one_x_max",   32'h0000_0001, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 2,  5);
    run_case("max_x_max",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 32, 5);
    run_case("max_x_min",   32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 32, 5);
    run_case("min_x_min",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 5);
    run_case("neg1_x_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2,  5);
    run_case("min_x_neg1",  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 5);
    run_case("zero_x_min",  32'h0000_0000, 32'h8000_0000, 64'h0000_0000_0000_0000, 2,  5);
    run_case("x_x_zero",    32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000, 2,  5);
    run_case("three_x_m5",  32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 3,  5);
  endtask

  task automatic test_mid_reset();
    int pulses[3];
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    mlier = 32'h7FFF_FFFF;
    mcand = 32'h0000_0003;
    start = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (get_prodt(i) !== 64'h0) begin
        tests_failed++;
        $display("FAIL mid_reset_async[%0d] prodt: got %h want 0", i, get_prodt(i));
      end
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) if (get_valid(i) !== 1'b0) pulses[i]++;
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pulses[i] !== 0) begin
        tests_failed++;
        $display("FAIL mid_reset[%0d] valid cycles: got %0d want 0", i, pulses[i]);
      end
      tests_run++;
      if (get_prodt(i) !== 64'h0) begin
        tests_failed++;
        $display("FAIL mid_reset[%0d] prodt: got %h want 0", i, get_prodt(i));
      end
    end
    run_case("post_reset", 32'hFFFF_FFFE, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF2, 3, 5);
  endtask

  task automatic test_back_to_back();
    run_case("b2b_first",  32'h0000_0005, 32'h0000_0006, 64'h0000_0000_0000_001E, 4, 1);
    run_case("b2b_second", 32'hFFFF_FFF9, 32'h0001_0000, 64'hFFFF_FFFF_FFF9_0000, 4, 5);
  endtask

  initial begin
    test_reset();
    test_products();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
